// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared constants and types for CPU pipeline stage registers
package cpu_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } pipe_beat_t;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// rtl/pipe_stage_hs_if.sv - valid/ready/data handshake bundle for pipeline stages
interface pipe_stage_hs_if
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = XLEN
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - one-entry skid register whose emptiness is the registered upstream ready
module pipe_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_unload,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Load (downstream stalled) and unload (downstream accepting) are mutually exclusive.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ready = !r_valid;

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - handshaked pipeline stage register with flush; skid buffer under PIPE_STAGE_SKID_EN
module pipe_stage_hs
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W       = XLEN,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  pipe_stage_hs_if.slave         up,
  pipe_stage_hs_if.master        dn
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in_xfer  = up.valid && w_ready;
  assign w_out_xfer = r_valid && dn.ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_load;

  assign w_skid_load = w_in_xfer && r_valid && !dn.ready;

  pipe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (flush_i),
    .i_load   (w_skid_load),
    .i_data   (up.data),
    .i_unload (w_out_xfer),
    .o_valid  (w_skid_valid),
    .o_data   (w_skid_data),
    .o_ready  (w_ready)
  );

  // The skid entry is older than any new input, so it refills main first.
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      r_valid <= 1'b0;
      r_data  <= DEFAULT_DATA;
    end else if (w_skid_valid && w_out_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_skid_data;
    end else if (w_in_xfer && !w_skid_load) begin
      r_valid <= 1'b1;
      r_data  <= up.data;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
      r_data  <= DEFAULT_DATA;
    end
  end
`else
  assign w_ready = dn.ready || !r_valid;

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      r_valid <= 1'b0;
      r_data  <= DEFAULT_DATA;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_data  <= up.data;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
      r_data  <= DEFAULT_DATA;
    end
  end
`endif

  assign up.ready = w_ready;
  assign dn.valid = r_valid;
  assign dn.data  = r_data;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - directed and scoreboarded checks of pipe_stage_hs
module tb_pipe_stage_hs;

  logic clk;
  logic rst;
  logic flush_i;
  int   total;
  int   bad;

  pipe_stage_hs_if #(.DATA_W(32)) up_if ();
  pipe_stage_hs_if #(.DATA_W(32)) dn_if ();

  pipe_stage_hs #(
    .DATA_W       (32),
    .DEFAULT_DATA (32'h0000_0013)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .up      (up_if.slave),
    .dn      (dn_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0;
    up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;
    step(); step();
    rst = 1'b1; #1;
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dn_if.valid); end
    total++; if (dn_if.data !== 32'h13) begin bad++; $display("FAIL reset_data got=%h exp=00000013", dn_if.data); end
    total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", up_if.ready); end
  endtask

  task automatic test_stream();
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up_if.valid = 1'b1; up_if.data = 32'(i);
      #1;
      total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL stream_ready beat=%0d got=%b exp=1", i, up_if.ready); end
      step();
      total++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'(i)) begin
        bad++; $display("FAIL stream_data beat=%0d got=%b/%h exp=1/%h", i, dn_if.valid, dn_if.data, 32'(i));
      end
    end
    up_if.valid = 1'b0;
    step();
    total++; if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h13) begin
      bad++; $display("FAIL stream_drain got=%b/%h exp=0/00000013", dn_if.valid, dn_if.data);
    end
  endtask

  task automatic test_backpressure();
    dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = 32'hA5A5_0001;
    step();
    total++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hA5A5_0001) begin
      bad++; $display("FAIL bp_first got=%b/%h exp=1/a5a50001", dn_if.valid, dn_if.data);
    end
    up_if.data = 32'hA5A5_0002;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL bp_skid_open got=%b exp=1", up_if.ready); end
`else
    total++; if (up_if.ready !== 1'b0) begin bad++; $display("FAIL bp_ready_comb got=%b exp=0", up_if.ready); end
`endif
    for (int c = 0; c < 3; c++) begin
      step();
`ifdef PIPE_STAGE_SKID_EN
      up_if.valid = 1'b0;
`endif
      total++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hA5A5_0001) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/a5a50001", c, dn_if.valid, dn_if.data);
      end
      total++; if (up_if.ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0", c, up_if.ready); end
    end
    dn_if.ready = 1'b1;
    step();
    up_if.valid = 1'b0;
    total++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hA5A5_0002) begin
      bad++; $display("FAIL bp_second got=%b/%h exp=1/a5a50002", dn_if.valid, dn_if.data);
    end
    step();
    total++; if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h13) begin
      bad++; $display("FAIL bp_empty got=%b/%h exp=0/00000013", dn_if.valid, dn_if.data);
    end
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = 32'hA5A5_0001;
    step();
    up_if.data = 32'hA5A5_0002;
    step();
    up_if.data = 32'hA5A5_0003; flush_i = 1'b1;
    step();
    flush_i = 1'b0; up_if.valid = 1'b0;
    total++; if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h13 || up_if.ready !== 1'b1) begin
      bad++; $display("FAIL flush_stall got=%b/%h/%b exp=0/00000013/1", dn_if.valid, dn_if.data, up_if.ready);
    end
    dn_if.ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL flush_no_leak cyc=%0d got=%b/%h exp=0", c, dn_if.valid, dn_if.data); end
    end
    up_if.valid = 1'b1; up_if.data = 32'hA5A5_0004; flush_i = 1'b1;
    step();
    flush_i = 1'b0; up_if.valid = 1'b0;
    total++; if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h13) begin
      bad++; $display("FAIL flush_with_input got=%b/%h exp=0/00000013", dn_if.valid, dn_if.data);
    end
    up_if.valid = 1'b1; up_if.data = 32'hA5A5_0005;
    step();
    up_if.valid = 1'b0;
    total++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hA5A5_0005) begin
      bad++; $display("FAIL flush_reload got=%b/%h exp=1/a5a50005", dn_if.valid, dn_if.data);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++; if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h13) begin
      bad++; $display("FAIL flush_with_output got=%b/%h exp=0/00000013", dn_if.valid, dn_if.data);
    end
  endtask

  task automatic test_reset_mid();
    dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = 32'h0000_0011;
    step();
    up_if.data = 32'h0000_0022;
    step();
    total++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'h11) begin
      bad++; $display("FAIL rstmid_pre got=%b/%h exp=1/00000011", dn_if.valid, dn_if.data);
    end
    rst = 1'b0;
    step();
    rst = 1'b1; up_if.valid = 1'b0;
    total++; if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h13 || up_if.ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_post got=%b/%h/%b exp=0/00000013/1", dn_if.valid, dn_if.data, up_if.ready);
    end
    dn_if.ready = 1'b1;
    step();
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_leak got=%b/%h exp=0", dn_if.valid, dn_if.data); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        in_x;
    logic        out_x;
    int          err_before;
    prev_stall = 1'b0; prev_data = '0;
    up_if.valid = 1'b0; flush_i = 1'b0;
    err_before = bad;
    for (int c = 0; c < 10000; c++) begin
      if (!up_if.valid) begin
        up_if.valid = 1'($urandom_range(0, 1));
        up_if.data  = $urandom;
      end
      dn_if.ready = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 99) < 2);
      #1;
      total++; if (!dn_if.valid && dn_if.data !== 32'h13) begin
        bad++; $display("FAIL rnd_default cyc=%0d got=%h exp=00000013", c, dn_if.data);
      end
      if (prev_stall) begin
        total++; if (dn_if.valid !== 1'b1 || dn_if.data !== prev_data) begin
          bad++; $display("FAIL rnd_stable cyc=%0d got=%b/%h exp=1/%h", c, dn_if.valid, dn_if.data, prev_data);
        end
      end
      total++; if (dn_if.valid !== (q.size() != 0)) begin
        bad++; $display("FAIL rnd_occupancy cyc=%0d got=%b exp=%0d", c, dn_if.valid, q.size());
      end
`ifdef PIPE_STAGE_SKID_EN
      total++; if (up_if.ready !== (q.size() < 2)) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, up_if.ready, (q.size() < 2));
      end
`else
      total++; if (up_if.ready !== (dn_if.ready || q.size() == 0)) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, up_if.ready, (dn_if.ready || q.size() == 0));
      end
`endif
      in_x  = up_if.valid && up_if.ready;
      out_x = dn_if.valid && dn_if.ready;
      if (out_x) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_order cyc=%0d got=%h exp=empty", c, dn_if.data);
        end else begin
          if (dn_if.data !== q[0]) begin bad++; $display("FAIL rnd_order cyc=%0d got=%h exp=%h", c, dn_if.data, q[0]); end
          void'(q.pop_front());
        end
      end
      prev_stall = dn_if.valid && !dn_if.ready && !flush_i;
      prev_data  = dn_if.data;
      if (flush_i) q.delete();
      else if (in_x) q.push_back(up_if.data);
      step();
      if (in_x || flush_i) up_if.valid = 1'b0;
      if (bad - err_before > 20) begin
        $display("FAIL rnd_abort cyc=%0d errors=%0d exp=0", c, bad - err_before);
        break;
      end
    end
    flush_i = 1'b0; up_if.valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, and an optional skid buffer. It sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the plain hold-to-default register with backpressure-aware flow control. Bubbles and flushed slots always present `DEFAULT_DATA`, e.g. the NOP encoding, downstream.

## Interface
- `DATA_W`, 32, payload width in bits (≥1)
- `DEFAULT_DATA`, `32'h0000_0013`, value driven on `data_o` whenever `valid_o`=0; width `DATA_W`
- `clk` input 1 rising-edge clock
- `rst` input 1 reset: synchronous, active-low
- `flush_i` input 1 synchronous squash of all held contents
- `valid_i` input 1 upstream beat valid
- `ready_o` output 1 stage can accept a beat
- `data_i` input `DATA_W` upstream payload
- `valid_o` output 1 downstream beat valid
- `ready_i` input 1 downstream accepts
- `data_o` output `DATA_W` downstream payload

## Operation
- Input transfer: `valid_i && ready_o` at a rising edge. Output transfer: `valid_o && ready_i` at a rising edge.
- Priority at each edge: `rst`=0 > `flush_i`=1 > normal flow.
- Reset and flush have the same effect:
  - `valid_o`=0, `data_o`=`DEFAULT_DATA`, skid entry emptied.
  - A beat accepted in the flush cycle is discarded.
- Invariant: `valid_o`=0 implies `data_o`=`DEFAULT_DATA`. When the last beat drains with no new input, `data_o` reloads `DEFAULT_DATA`.
- Data is never dropped or duplicated except by flush.
- Beats leave in arrival order.
- `valid_o` does not deassert while `ready_i`=0.
- `data_o` is stable while `valid_o && !ready_i`.
- Upstream must hold `valid_i`/`data_i` stable until accepted; this block does not check it.
- Base mode, no skid:
  - Single main register.
  - `ready_o = ready_i || !valid_o`. This is a combinational path from `ready_i`.
  - On input transfer, main loads `data_i` and `valid_o`←1.
  - On output transfer without input transfer, `valid_o`←0.
- Skid mode: see Configuration.

## Timing
- Latency: a beat accepted at edge N appears on `data_o`/`valid_o` after edge N, so it is visible in cycle N+1.
- Throughput: 1 beat/cycle sustained while `ready_i`=1, in both modes.
- After reset release: `ready_o`=1 in the first cycle.
- Flush and input in the same cycle: the input is dropped and `valid_o`=0 next cycle.
- Flush and output handshake in the same cycle: downstream's acceptance stands, and the stage is empty next cycle.
- Reset mid-stall: all contents are lost and outputs return to reset values at the next edge.
- No combinational path from `flush_i` to any output.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- Undefined:
  - Base mode.
  - `ready_o` depends combinationally on `ready_i`.
  - Storage is 1 entry.
- Defined:
  - A one-entry skid register is added and `ready_o` is registered: `ready_o = !skid_valid`. This breaks the backward ready path.
  - When `valid_o && !ready_i` and an input transfer occurs, the beat goes to the skid register and `ready_o`←0 next cycle.
  - On the next output transfer, main loads from skid, skid empties, and `ready_o`←1.
  - Maximum occupancy is 2.
  - `ready_o` reset value is 1.
  - Flush empties skid and sets `ready_o`←1.

## Structure
- Shared package `cpu_pipe_pkg`:
  - `NOP_INSTR` = `32'h0000_0013`
  - `XLEN` = 32
  - Optional `pipe_beat_t` struct {valid, data} for stage wrappers.
- Sub-module `pipe_skid_buf`:
  - Holds the skid entry and registered ready.
  - Instantiated only under `PIPE_STAGE_SKID_EN`.
- Top level holds the main register, the priority logic, and the default-data invariant.

## Test plan
- Reset, then idle:
  - Hold `rst`=0 for 2 cycles, release.
  - Required: `valid_o`=0, `data_o`=`32'h13`, `ready_o`=1.
- Streaming:
  - Drive `data_i`=1,2,3,4 on consecutive cycles, `ready_i`=1.
  - Required: `data_o`=1,2,3,4 one cycle later, no gaps; then `data_o` returns to `32'h13` with `valid_o`=0.
- Backpressure:
  - Send `A5A5_0001`, then `0002`, with `ready_i`=0 for 3 cycles.
  - Required: `data_o` held at `0001`.
  - Base mode: `ready_o`=0 during the stall.
  - Skid mode: `0002` is accepted into skid, then `ready_o`=0.
  - After release: `0001` then `0002`, with no loss or duplication.
- Flush during stall:
  - Stage holds `0001` (and `0002` in skid); assert `flush_i` for 1 cycle while `valid_i`=1 with `0003`.
  - Required: next cycle `valid_o`=0, `data_o`=`32'h13`, `ready_o`=1, and `0003` never appears.
- Reset mid-operation:
  - Stall with valid data, assert `rst`=0 for 1 cycle.
  - Required: same outputs as after a flush.
- Random:
  - Random `valid_i`/`ready_i`/`flush_i` (flush 2%) for 10k cycles, checked against a scoreboard queue.
  - Required: in-order delivery, the stability rules above hold, and the `DEFAULT_DATA` invariant is never violated.
